// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the datapath and the dmem_lsu data memory.
// Master issues load/store requests under valid/ready; slave returns one unstalled response per request.
interface dmem_lsu_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// RISC-V byte/half/word load-store data memory with misalignment detection; response READ_LAT cycles after acceptance.
// req_ready drops only during reset or the post-reset clear (DMEM_CLEAR_EN); responses are never backpressured.
module dmem_lsu #(
    parameter int WORDS    = 256,
    parameter int READ_LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_lsu_if.slave bus
);
    localparam int ADDR_W = $clog2(WORDS) + 2;
    localparam int IDX_W  = ADDR_W - 2;

    logic [31:0] r_mem [WORDS] = '{default: '0};

    logic              w_run;
    logic              w_acc;
    logic              w_err;
    logic              w_st;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdat;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_rdat;

    logic [READ_LAT-1:0] r_pv;
    logic [READ_LAT-1:0] r_pe;
    logic [31:0]         r_pd [READ_LAT];

`ifdef DMEM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx, w_clr_idx_nxt;
    logic             w_clr_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        w_run         = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == IDX_W'(WORDS - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN:   w_run = 1'b1;
            default: w_state_nxt = S_CLEAR;
        endcase
    end
`else
    assign w_run = 1'b1;
`endif

    assign bus.req_ready = rst_n && w_run;
    assign w_acc  = bus.req_valid && bus.req_ready;
    assign w_idx  = bus.req_addr[ADDR_W-1:2];
    assign w_lane = bus.req_addr[1:0];
    assign w_st   = w_acc && bus.req_we && !w_err;

    always_comb begin
        w_err = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'd0:    w_err = 1'b0;
                3'd1:    w_err = w_lane[0];
                3'd2:    w_err = |w_lane;
                default: w_err = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'd0, 3'd4: w_err = 1'b0;
                3'd1, 3'd5: w_err = w_lane[0];
                3'd2:       w_err = |w_lane;
                default:    w_err = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        w_be   = 4'b0000;
        w_wdat = '0;
        case (bus.req_funct3[1:0])
            2'd0: begin
                w_be   = 4'b0001 << w_lane;
                w_wdat = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                w_be   = 4'b0011 << w_lane;
                w_wdat = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                w_be   = 4'b1111;
                w_wdat = bus.req_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (rst_n && w_clr_we)
            r_mem[r_clr_idx] <= '0;
        else
`endif
        if (w_st) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_rword[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_rdat = '0;
        if (!bus.req_we && !w_err) begin
            case (bus.req_funct3)
                3'd0:    w_rdat = {{24{w_byte[7]}}, w_byte};
                3'd1:    w_rdat = {{16{w_half[15]}}, w_half};
                3'd2:    w_rdat = w_rword;
                3'd4:    w_rdat = {24'd0, w_byte};
                3'd5:    w_rdat = {16'd0, w_half};
                default: w_rdat = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pe <= '0;
            for (int i = 0; i < READ_LAT; i++)
                r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_acc;
            r_pe[0] <= w_acc && w_err;
            r_pd[0] <= w_acc ? w_rdat : 32'd0;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign bus.rsp_valid = r_pv[READ_LAT-1];
    assign bus.rsp_err   = r_pe[READ_LAT-1];
    assign bus.rsp_rdata = r_pd[READ_LAT-1];
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised synchronous data memory with a RISC-V load/store front end: byte, halfword and word accesses with sign or zero extension and byte-lane write enables. It also detects misaligned accesses, has a configurable read latency and provides a valid/ready request handshake. It sits between the datapath's ALU result and register-read ports and the write-back mux, replacing the fixed word-only 256×32 data RAM. An optional post-reset clear sequencer zeroes the array before the first access.

## Interface
- WORDS, 256: array depth in 32-bit words; power of two, 16..4096.
- READ_LAT, 1: cycles from request acceptance to response; legal range 1..4.
- ADDR_W, $clog2(WORDS)+2: byte-address width (derived; do not override).
- clk  in  1: single clock; all state changes on its rising edge.
- rst_n  in  1: synchronous, active-low reset, sampled on rising clk.
- req_valid  in  1: request present.
- req_ready  out  1: block accepts a request this cycle.
- req_we  in  1: 1 = store, 0 = load.
- req_funct3  in  3: RISC-V funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- req_addr  in  ADDR_W: byte address; bits above ADDR_W-1 are not connected, so addresses wrap modulo 4×WORDS.
- req_wdata  in  32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  out  1: one-cycle pulse per accepted request.
- rsp_rdata  out  32: extended load data; 0 for stores and errors.
- rsp_err  out  1: misaligned address or illegal funct3 for the access type.

## Operation
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. There is no response backpressure.
- FSM states:
  - CLEAR: req_ready=0. The counter steps through 0..WORDS-1 and writes 0 to each word. After the WORDS-1 write, the FSM goes to RUN.
  - RUN: req_ready=1.
- Word index is req_addr[ADDR_W-1:2]. Lane select is req_addr[1:0].
- Error conditions (rsp_err=1):
  - LH, LHU or SH with addr[0]=1.
  - LW or SW with addr[1:0]≠0.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 other than 0, 1 or 2.
- An erroring access does not modify the array and returns rsp_rdata=0.
- Stores: write only the addressed lanes (SB one byte, SH two bytes, SW all four) at the acceptance edge. All other bytes of the word are preserved.
- Loads: read the word as it stands before the acceptance edge. Because only one request is accepted per cycle, a store accepted at edge k is visible to a load accepted at edge k+1.
- Extension: LB and LH sign-extend from bit 7 and bit 15. LBU and LHU zero-extend.
- Response path: a READ_LAT-deep shift pipeline carries {valid, err, data}. Responses return in acceptance order. Up to READ_LAT requests can be in flight.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All pipeline stages cleared; in-flight responses are discarded and never appear.
  - FSM to CLEAR with counter=0 (macro on), or to RUN (macro off).
- While rst_n=0, req_ready=0.
- Response timing for a request accepted at edge k: rsp_valid, rsp_rdata and rsp_err are high/valid in the cycle after edge k+READ_LAT-1, for exactly one cycle.
  - With READ_LAT=1, the response is visible immediately after the acceptance edge.
- Back-to-back requests every cycle give back-to-back rsp_valid pulses.
- Reset mid-CLEAR restarts the clear from word 0.

## Configuration
- DMEM_CLEAR_EN defined:
  - The CLEAR state exists. After rst_n is released, req_ready is first high exactly WORDS cycles later.
  - Array contents are zero at that point.
- DMEM_CLEAR_EN undefined:
  - The CLEAR state and its counter are removed. req_ready is high in the first cycle after rst_n is released.
  - Array contents survive reset; the initial contents are all zero.

## Test plan
- Reset/clear (macro on, WORDS=256): release rst_n → req_ready low for 256 cycles, then high. LW at 0x3FC → rsp_rdata=0x00000000, rsp_err=0.
- Byte lanes: SW 0x11223344 @0x10, then SB 0xAA @0x11, SH 0xBEEF @0x12, then LW @0x10 → 0xBEEFAA44.
- Extension: after the lane test, LB @0x11 → 0xFFFFFFAA, LBU @0x11 → 0x000000AA, LH @0x12 → 0xFFFFBEEF, LHU @0x12 → 0x0000BEEF.
- Misaligned/illegal accesses:
  - SW 0xDEADBEEF @0x21 → rsp_err=1, and a following LW @0x20 still returns its prior value.
  - LH @0x13 → err=1, rdata=0.
  - Load funct3=3 → err=1.
- Latency/throughput (READ_LAT=3): four LWs on consecutive edges k..k+3 → rsp_valid high in the cycles after edges k+2..k+5 with data in order. Store at k followed by load of the same word at k+1 → the load returns the stored data.
- Reset mid-flight (READ_LAT=4): two loads in flight, assert rst_n=0 for one edge → no rsp_valid pulse from those loads. With the macro on, the clear restarts (req_ready low for WORDS cycles).
